axis_rr_arbiter: RTL

Two-input, packet-granular round-robin arbiter that shares one AXI-Stream sink (the `axis_fifo` slave port) between two stream sources such as two `generator` instances. A grant is held from the first beat of a packet through its `tlast` beat, so packets are never interleaved. The output passes through one register stage. Per-port packet counters expose a traffic status view.

---
 rtl/axis_arb_pkg.sv | 25 ++
 rtl/axis_reg_slice.sv | 58 +++++
 rtl/axis_rr_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/axis_arb_pkg.sv
// Shared definitions for the two-port packet round-robin arbiter.
// State encoding and the grant decode used by the arbiter FSM.
package axis_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_P0   = 2'b01;
    localparam logic [1:0] GRANT_P1   = 2'b10;

    function automatic logic [1:0] grant_of(input arb_state_e st);
        logic [1:0] g;
        case (st)
            GNT0:    g = GRANT_P0;
            GNT1:    g = GRANT_P1;
            default: g = GRANT_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry AXI-Stream output register. A load always wins over a drain,
// so an accept and a drain in the same cycle keep tvalid high with new data.
module axis_reg_slice #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [DATA_WIDTH-1:0]   in_tdata,
    input  logic [DATA_WIDTH/8-1:0] in_tstrb,
    input  logic                    in_tlast,
    input  logic                    out_tready,
    output logic                    out_tvalid,
    output logic [DATA_WIDTH-1:0]   out_tdata,
    output logic [DATA_WIDTH/8-1:0] out_tstrb,
    output logic                    out_tlast
);

    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH/8-1:0] strb_q, strb_d;
    logic                    last_q, last_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        strb_d  = strb_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_tdata;
            strb_d  = in_tstrb;
            last_d  = in_tlast;
        end else if (out_tready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            strb_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            last_q  <= last_d;
        end
    end

    assign out_tvalid = valid_q;
    assign out_tdata  = data_q;
    assign out_tstrb  = strb_q;
    assign out_tlast  = last_q;

endmodule

// File: rtl/axis_rr_arbiter.sv
// Two-input packet-granular round-robin arbiter feeding one AXI-Stream sink
// through a register stage, with saturating per-port packet counters.
//
//   state | meaning
//   IDLE  | no owner, both slave treadys low, arbitrating on enable
//   GNT0  | port 0 owns the output until its tlast beat is accepted
//   GNT1  | port 1 owns the output until its tlast beat is accepted
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    m00_axis_aclk,
    input  logic                    m00_axis_aresetn,
    input  logic                    enable,

    input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                    s00_axis_tvalid,
    input  logic                    s00_axis_tlast,
    output logic                    s00_axis_tready,

    input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
    input  logic                    s01_axis_tvalid,
    input  logic                    s01_axis_tlast,
    output logic                    s01_axis_tready,

    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                    m00_axis_tvalid,
    output logic                    m00_axis_tlast,
    input  logic                    m00_axis_tready,

    output logic [1:0]              grant,
    output logic [CNT_WIDTH-1:0]    s00_pkt_count,
    output logic [CNT_WIDTH-1:0]    s01_pkt_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    arb_state_e             state_q, state_d;
    logic                   last_served_q, last_served_d;
    logic                   in_pkt_q, in_pkt_d;
    logic [CNT_WIDTH-1:0]   cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0]   cnt1_q, cnt1_d;

    logic       out_room;
    logic       acc0, acc1, accept;
    logic       owner1;
    logic       own_valid, oth_valid, own_last;
    arb_state_e oth_state;

    // Ready depends only on the owner state and the output stage, never on tvalid.
    assign out_room        = ~m00_axis_tvalid | m00_axis_tready;
    assign s00_axis_tready = (state_q == GNT0) & out_room;
    assign s01_axis_tready = (state_q == GNT1) & out_room;

    assign acc0   = s00_axis_tvalid & s00_axis_tready;
    assign acc1   = s01_axis_tvalid & s01_axis_tready;
    assign accept = acc0 | acc1;

    assign owner1    = (state_q == GNT1);
    assign own_valid = owner1 ? s01_axis_tvalid : s00_axis_tvalid;
    assign oth_valid = owner1 ? s00_axis_tvalid : s01_axis_tvalid;
    assign own_last  = owner1 ? s01_axis_tlast  : s00_axis_tlast;
    assign oth_state = owner1 ? GNT0 : GNT1;

    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        in_pkt_d      = in_pkt_q;
        cnt0_d        = cnt0_q;
        cnt1_d        = cnt1_q;
        case (state_q)
            IDLE: begin
                in_pkt_d = 1'b0;
                if (enable) begin
                    if (s00_axis_tvalid && s01_axis_tvalid) begin
                        state_d = last_served_q ? GNT0 : GNT1;
                    end else if (s00_axis_tvalid) begin
                        state_d = GNT0;
                    end else if (s01_axis_tvalid) begin
                        state_d = GNT1;
                    end
                end
            end
            GNT0, GNT1: begin
                if (accept) begin
                    if (own_last) begin
                        last_served_d = owner1;
                        in_pkt_d      = 1'b0;
                        if (owner1) begin
                            if (cnt1_q != CNT_MAX) cnt1_d = cnt1_q + CNT_WIDTH'(1);
                        end else begin
                            if (cnt0_q != CNT_MAX) cnt0_d = cnt0_q + CNT_WIDTH'(1);
                        end
                        if (oth_valid && enable) begin
                            state_d = oth_state;
                        end else if (own_valid && enable) begin
                            state_d = state_q;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        in_pkt_d = 1'b1;
                    end
                end else if (!in_pkt_q && !own_valid) begin
                    // Owner has nothing queued at a packet boundary: hand the grant on.
                    state_d = (oth_valid && enable) ? oth_state : IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                in_pkt_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state_q       <= IDLE;
            last_served_q <= 1'b1;
            in_pkt_q      <= 1'b0;
            cnt0_q        <= '0;
            cnt1_q        <= '0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            in_pkt_q      <= in_pkt_d;
            cnt0_q        <= cnt0_d;
            cnt1_q        <= cnt1_d;
        end
    end

    axis_reg_slice #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_slice (
        .clk        (m00_axis_aclk),
        .rst_n      (m00_axis_aresetn),
        .load       (accept),
        .in_tdata   (acc1 ? s01_axis_tdata : s00_axis_tdata),
        .in_tstrb   (acc1 ? s01_axis_tstrb : s00_axis_tstrb),
        .in_tlast   (acc1 ? s01_axis_tlast : s00_axis_tlast),
        .out_tready (m00_axis_tready),
        .out_tvalid (m00_axis_tvalid),
        .out_tdata  (m00_axis_tdata),
        .out_tstrb  (m00_axis_tstrb),
        .out_tlast  (m00_axis_tlast)
    );

    assign grant         = grant_of(state_q);
    assign s00_pkt_count = cnt0_q;
    assign s01_pkt_count = cnt1_q;

endmodule
